// File: rtl/lfsr_stream_cipher.sv
// Byte-stream XOR cipher keyed from a free-running 64-bit LFSR state.
// Reseeds the LFSR per message and refreshes the key word every 8 bytes.
module lfsr_stream_cipher (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  msg_len,
  input  logic [63:0] key_state,
  output logic        lfsr_load,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ARM, RUN, DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [2:0]  j_q, j_d;
  logic [63:0] key_q, key_d;
  logic [7:0]  obuf_q, obuf_d;
  logic        ovld_q, ovld_d;
  logic        done_q, done_d;

  logic        run_rdy;
  logic        accept;
  logic        out_hs;

  assign run_rdy = (state_q == RUN) &&
                   (!ovld_q || out_ready);
  assign accept  = run_rdy && in_valid;
  assign out_hs  = ovld_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      j_q     <= '0;
      key_q   <= '0;
      obuf_q  <= '0;
      ovld_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      j_q     <= j_d;
      key_q   <= key_d;
      obuf_q  <= obuf_d;
      ovld_q  <= ovld_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && (msg_len != 8'd0)) begin
          state_d = LOAD;
        end
      end
      LOAD: state_d = ARM;
      ARM:  state_d = RUN;
      RUN: begin
        if (accept && (rem_q == 8'd1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_d  = rem_q;
    j_d    = j_q;
    key_d  = key_q;
    obuf_d = obuf_q;
    ovld_d = ovld_q;
    done_d = 1'b0;

    if ((state_q == IDLE) && start) begin
      if (msg_len != 8'd0) begin
        rem_d = msg_len;
      end else begin
        done_d = 1'b1;
      end
    end

    // LFSR output equals the seed exactly in the ARM cycle
    if (state_q == ARM) begin
      key_d = key_state;
      j_d   = 3'd0;
    end

    if (out_hs) begin
      ovld_d = 1'b0;
    end

    if (accept) begin
      obuf_d = in_data ^ key_q[{j_q, 3'b000} +: 8];
      ovld_d = 1'b1;
      j_d    = j_q + 3'd1;
      rem_d  = rem_q - 8'd1;
      if (j_q == 3'd7) begin
        key_d = key_state;
      end
    end

    if ((state_q == DRAIN) && out_hs) begin
      done_d = 1'b1;
    end
  end

  always_comb begin
    lfsr_load = (state_q == LOAD);
    in_ready  = run_rdy;
    out_valid = ovld_q;
    out_data  = obuf_q;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Directed bench for lfsr_stream_cipher with a local XNOR-feedback LFSR
// driving key_state; expected ciphertext bytes are hand-derived constants.
module tb_lfsr_stream_cipher;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  msg_len;
  logic [63:0] key_state;
  logic        lfsr_load;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;

  lfsr_stream_cipher dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .msg_len   (msg_len),
    .key_state (key_state),
    .lfsr_load (lfsr_load),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // From seed 0 this LFSR shifts in ones: after n steps it holds n ones
  logic [63:0] seed = 64'd0;
  logic [63:0] lfsr = 64'd0;
  always @(posedge clk) begin
    if (lfsr_load) lfsr <= seed;
    else lfsr <= {lfsr[62:0], ~(lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59])};
  end
  assign key_state = lfsr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         tid;
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[$];

  logic [7:0] outs[64];
  int acc_t[64];
  int n_load, n_done, done_cyc, last_hs, nout;
  int hold_seen, hold_err;
  bit timed_out;
  logic done_busy;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input int tid, input int idx, input logic [7:0] e);
    vec_t v;
    v.tid = tid; v.idx = idx; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic check_vecs(input int tid);
    foreach (vt[k]) begin
      if (vt[k].tid == tid) begin
        chk($sformatf("t%0d byte%0d", tid, vt[k].idx),
            {56'd0, outs[vt[k].idx]}, {56'd0, vt[k].exp});
      end
    end
  endtask

  task automatic run_msg(input int len, input int stall_after,
                         input int stall_n, input int abort_after,
                         input int restart_at);
    int idx, cyc, t0, s_from, s_to;
    bit fin, hold_pend;
    logic [7:0] hold_v;
    idx = 0; cyc = 0; t0 = -1000; s_from = -1; s_to = -2;
    fin = 0; hold_pend = 0; hold_v = 0;
    n_load = 0; n_done = 0; done_cyc = -1; last_hs = -1; nout = 0;
    hold_seen = 0; hold_err = 0; timed_out = 0; done_busy = 1'b1;
    for (int k = 0; k < 64; k++) begin
      outs[k] = 8'd0; acc_t[k] = -1;
    end
    while (!fin) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == restart_at);
      msg_len = (cyc == 0) ? len[7:0] : 8'd3;
      in_valid = 1'b1;
      in_data = idx[7:0];
      out_ready = !(cyc >= s_from && cyc <= s_to);
      #1;
      if (hold_pend) begin
        hold_seen++;
        if (out_data !== hold_v) hold_err++;
      end
      hold_pend = out_valid && !out_ready;
      hold_v = out_data;
      if (lfsr_load) begin n_load++; t0 = cyc + 1; end
      if (done) begin
        n_done++; done_cyc = cyc; done_busy = busy; fin = 1;
      end
      if (out_valid && out_ready && nout < 64) begin
        outs[nout] = out_data; nout++; last_hs = cyc;
      end
      if (in_valid && in_ready && idx < 64) begin
        acc_t[idx] = cyc - t0;
        if (idx == stall_after) begin
          s_from = cyc + 1; s_to = cyc + stall_n;
        end
        idx++;
      end
      cyc++;
      if (abort_after >= 0 && idx == abort_after) fin = 1;
      if (cyc > 400) begin timed_out = 1; fin = 1; end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic idle_watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (lfsr_load) n_load++;
      if (done) n_done++;
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " lfsr_load"}, {63'd0, lfsr_load}, 64'd0);
    chk({tag, " in_ready"},  {63'd0, in_ready},  64'd0);
    chk({tag, " out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " out_data"},  {56'd0, out_data},  64'd0);
    chk({tag, " busy"},      {63'd0, busy},      64'd0);
    chk({tag, " done"},      {63'd0, done},      64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; msg_len = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;

    for (int i = 0; i < 16; i++)
      add(1, i, (i == 8) ? 8'hF7 : 8'(i));
    for (int i = 0; i < 24; i++) begin
      case (i)
        8:       add(2, i, 8'hF7);
        16:      add(2, i, 8'hEF);
        17:      add(2, i, 8'hEE);
        18:      add(2, i, 8'h15);
        default: add(2, i, 8'(i));
      endcase
    end
    add(4, 0, 8'hEF); add(4, 1, 8'hCC); add(4, 2, 8'hA9);
    add(4, 3, 8'h8A); add(4, 4, 8'h63); add(4, 5, 8'h40);
    add(4, 6, 8'h25); add(4, 7, 8'h06);

    #3;
    chk_outputs_zero("reset");
    @(negedge clk); reset = 1'b0;
    idle_watch(3);
    chk("post-reset lfsr_load count", n_load, 0);

    // Unstalled 16-byte message
    seed = 64'd0;
    run_msg(16, -1, 0, -1, -1);
    chk("t1 timeout", {63'd0, timed_out}, 64'd0);
    chk("t1 lfsr_load pulses", n_load, 1);
    chk("t1 bytes out", nout, 16);
    chk("t1 byte0 accept t", acc_t[0], 1);
    chk("t1 byte15 accept t", acc_t[15], 16);
    chk("t1 done cycle", done_cyc, last_hs + 1);
    chk("t1 busy at done", {63'd0, done_busy}, 64'd0);
    check_vecs(1);
    idle_watch(2);

    // Backpressure after byte 7
    run_msg(24, 7, 3, -1, -1);
    chk("t2 timeout", {63'd0, timed_out}, 64'd0);
    chk("t2 lfsr_load pulses", n_load, 1);
    chk("t2 bytes out", nout, 24);
    chk("t2 byte8 accept t", acc_t[8], 12);
    chk("t2 byte15 accept t", acc_t[15], 19);
    chk("t2 held cycles", hold_seen, 3);
    chk("t2 hold changes", hold_err, 0);
    chk("t2 done cycle", done_cyc, last_hs + 1);
    check_vecs(2);
    idle_watch(2);

    // Zero-length message
    n_load = 0;
    @(negedge clk); start = 1'b1; msg_len = 8'd0;
    #1;
    chk("z busy start", {63'd0, busy}, 64'd0);
    @(negedge clk); start = 1'b0;
    #1;
    chk("z done", {63'd0, done}, 64'd1);
    chk("z busy", {63'd0, busy}, 64'd0);
    chk("z lfsr_load", {63'd0, lfsr_load}, 64'd0);
    @(negedge clk); #1;
    chk("z done cleared", {63'd0, done}, 64'd0);
    chk("z busy after", {63'd0, busy}, 64'd0);

    // Second start during RUN is ignored
    run_msg(16, -1, 0, -1, 6);
    idle_watch(4);
    chk("t3 timeout", {63'd0, timed_out}, 64'd0);
    chk("t3 lfsr_load pulses", n_load, 1);
    chk("t3 done pulses", n_done, 1);
    chk("t3 bytes out", nout, 16);
    check_vecs(3 - 2);

    // Reset mid-message, then replay with a distinct seed
    run_msg(16, -1, 0, 5, -1);
    chk("t4 out_valid before reset", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_outputs_zero("mid reset");
    @(negedge clk); reset = 1'b0;
    n_load = 0; n_done = 0;
    idle_watch(3);
    chk("t4 no load after reset", n_load, 0);
    chk("t4 no done after reset", n_done, 0);
    seed = 64'h0123456789ABCDEF;
    run_msg(8, -1, 0, -1, -1);
    chk("t4 timeout", {63'd0, timed_out}, 64'd0);
    chk("t4 lfsr_load pulses", n_load, 1);
    chk("t4 bytes out", nout, 8);
    chk("t4 done cycle", done_cyc, last_hs + 1);
    check_vecs(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_cipher.md
# lfsr_stream_cipher

Byte-stream XOR cipher stage that consumes the free-running 64-bit LFSR state as keystream. On `start` it pulses `lfsr_load` to reseed the LFSR. It captures one 64-bit key word at a deterministic cycle and XORs incoming plaintext bytes with successive key bytes, recapturing a fresh LFSR word every 8 bytes. It sits directly downstream of the LFSR and upstream of the output/transmit logic, using valid/ready handshakes on both byte streams.

## Interface
- No parameters. Byte width is 8 and key width is 64, both fixed.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: begin a message; sampled only in IDLE.
- `msg_len` input 8: message length in bytes, sampled with `start`; 0 is legal.
- `key_state` input 64: current LFSR state, which advances one step every clock.
- `lfsr_load` output 1: one-cycle reseed pulse, wired to the LFSR reset/load input.
- `in_valid` input 1, `in_ready` output 1, `in_data` input 8: plaintext stream.
- `out_valid` output 1, `out_ready` input 1, `out_data` output 8: ciphertext stream.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse when a message completes.

## Operation
- States: IDLE, LOAD, ARM, RUN, DRAIN.
- **IDLE**
  - `start` with `msg_len`≠0 → LOAD; latch `msg_len` into the remaining-byte counter `rem`.
  - `start` with `msg_len`=0 → stay in IDLE; `done`=1 next cycle; no `lfsr_load`.
- **LOAD:** `lfsr_load`=1 for exactly this cycle → ARM.
- **ARM:**
  - `key_state` equals the seed this cycle; capture it into the 64-bit key register.
  - Clear the byte index `j` (3 bits) → RUN.
- **RUN:**
  - `in_ready` = `!out_valid || out_ready`.
  - Accept occurs when `in_valid && in_ready`.
  - On accept:
    - Output register ← `in_data ^ key[8j+7:8j]`; `out_valid`←1.
    - `j`←`j+1`, wrapping 7→0.
    - `rem`←`rem-1`.
  - On accept with `j`=7: capture `key_state` of that same cycle into the key register. This also happens on the final byte.
  - Accept with `rem`=1 → DRAIN.
- **DRAIN:** `in_ready`=0; when `out_valid && out_ready` → IDLE with `done`=1 for one cycle.
- **Output register rules:**
  - `out_valid` clears on `out_ready` unless a new accept occurs in the same cycle.
  - `out_data` is held stable while `out_valid && !out_ready`.
- `start` outside IDLE is ignored.
- `in_ready`=0 in every state except RUN.

## Timing
- Reset values: `lfsr_load`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, state IDLE, key=0, `j`=0, `rem`=0.
- Reset mid-message aborts immediately: no `done`, and pending output is discarded.
- Define t=0 as the ARM cycle.
  - `start` is seen at t=-2; `lfsr_load` is high at t=-1.
- With no stalls, byte i is accepted at t=1+i and appears on `out_data` at t=2+i.
- Key word k is the `key_state` value at the cycle of the accept of byte 8k-1 (k≥1), or at t=0 (k=0).
  - Stalls shift the capture cycles accordingly.
- `done` goes high the cycle after the final output handshake; `busy` falls in that same cycle.
- Throughput is 1 byte/clock under continuous valid/ready.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle.
  - → all outputs 0 immediately.
  - → `lfsr_load` stays 0 after release.
- **Unstalled message:** bench LFSR seed=0, `msg_len`=16, `in_data`=0x00..0x0F, `in_valid`/`out_ready` held high.
  - → single `lfsr_load` pulse.
  - → outputs 0x00..0x07 unchanged; byte 8 = 0xF7 (key word 0x00000000000000FF); bytes 9..15 unchanged.
  - → `done` pulse one cycle after the last handshake.
- **Backpressure:** seed=0, `msg_len`=24, `in_data`=index, `out_ready`=0 for the 3 cycles after byte 7 is accepted.
  - → byte 8 = 0xF7.
  - → byte 15 is accepted at t=19; key word = 0x7FFFF.
  - → byte 16 = 0xEF, byte 17 = 0xEE, byte 18 = 0x15.
  - → `out_data` is held stable during the stall.
- **Zero length:** `msg_len`=0 → `done`=1 the next cycle; no `lfsr_load`; `busy` stays 0.
- **Start while busy:** second `start` pulse during RUN → ignored; only one `lfsr_load` pulse and one `done` pulse.
- **Reset mid-message:** `reset` after 5 bytes → `out_valid`=0 and `busy`=0; a new `start` replays from `lfsr_load` with key word 0 equal to the seed.
